uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO placed between the ROM-driven byte sequencer and the buart transmitter.
//  Accepts single-cycle byte pushes from the producer and absorbs bursts.
//  Drains bytes to buart with a wr strobe paced by the buart busy flag, so the
//  producer no longer stalls in its own UART wait states.
// PARAMETERS
//  DEPTH_LOG2  4  log2 of FIFO depth (default 16 entries); must be >= 1
//  WIDTH       8  data width in bits
// PORTS
//  clk         in   1           single clock; all state on posedge clk
//  resetq      in   1           asynchronous, active-low reset
//  push        in   1           write request; 1 cycle = 1 byte
//  push_data   in   WIDTH       byte written when push=1 and full=0
//  full        out  1           registered; 1 when count == 2**DEPTH_LOG2
//  empty       out  1           registered; 1 when count == 0
//  level       out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
//  uart_busy   in   1           buart busy; 1 while a byte is shifting out
//  uart_wr     out  1           one-cycle strobe to buart wr
//  uart_data   out  WIDTH       byte presented to buart tx_data; held stable
//  overflow    out  1           sticky: a push was dropped because the FIFO was full
//  ovf_clr     in   1           clears overflow (synchronous)
// BEHAVIOUR
//  Reset (resetq=0, asynchronous): pointers=0, level=0, empty=1, full=0, uart_wr=0,
//   uart_data=0, overflow=0, state=S_IDLE. Storage contents are not reset.
//   Asserting reset in any state aborts the drain. A byte already handed to buart
//   is not recalled.
//  Pointers: wr_ptr and rd_ptr are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1).
//   level = wr_ptr - rd_ptr, truncated. full/empty are derived from the next-state level.
//  Push: accepted iff push=1 and full=0 at that edge. It writes mem[wr_ptr] and
//   increments wr_ptr. Push while full: the byte is dropped and pointers are unchanged.
//  Drain FSM, 3 states:
//   S_IDLE:   if !empty && !uart_busy: uart_data <= mem[rd_ptr]; rd_ptr++;
//             uart_wr <= 1; go S_STROBE.
//   S_STROBE: uart_wr <= 0; go S_GAP.
//   S_GAP:    one dead cycle so buart raises busy; go S_IDLE.
//   uart_wr is high for exactly 1 cycle per byte. Strobes are at least 3 cycles
//   apart even if busy never asserts.
//  Latency: a push into an empty FIFO with uart_busy=0 at edge N gives empty=0
//   after N. uart_wr=1 after edge N+1 (2-cycle push-to-strobe).
//  Simultaneous push and pop:
//   - Both happen; level is unchanged.
//   - At full, the push is still dropped: full is sampled before the pop.
//   - At empty, no pop occurs in that cycle.
//  Byte order is strictly FIFO. No byte is duplicated or skipped across pointer wrap.
// CONFIGURATION
//  UART_TX_FIFO_OVF_EN:
//   defined: overflow sets on a dropped push. ovf_clr clears it. If set and clear
//    occur in the same cycle, set wins.
//   undefined: overflow is tied to 0, ovf_clr is ignored, and no flop is inferred.
//   The port list is identical in both builds.
// STRUCTURE
//  Shared include (uart_defs.vh): drain state encodings S_IDLE=2'b00,
//   S_STROBE=2'b01, S_GAP=2'b10, plus the default WIDTH.
//  One sub-module, fifo_mem_2r1w: a DEPTH x WIDTH register array with synchronous
//   write and asynchronous read.
//  Pointers, flags and the drain FSM live in uart_tx_fifo.
// TESTING
//  1 Reset, then push 0x41 with uart_busy=0 -> uart_wr=1 with uart_data=0x41
//    2 cycles later. empty=1 after the pop.
//  2 Hold busy=1 and push 16 bytes 0x00..0x0F -> full=1, level=16, no uart_wr.
//    Release busy (busy model 10 cycles per byte) -> 16 strobes carry 0x00..0x0F in order.
//  3 Full FIFO, push 0xEE -> byte dropped, level stays 16.
//    With UART_TX_FIFO_OVF_EN: overflow=1 until ovf_clr. Without the macro: overflow stays 0.
//  4 Level=1, push 0x55 on the same edge the drain pops -> level stays 1,
//    and the next byte sent is 0x55.
//  5 Push 40 bytes in 4 bursts of 10 across pointer wrap -> all 40 bytes are
//    received in order, with no duplicates.
//  6 Assert resetq=0 during S_STROBE -> uart_wr=0 immediately, empty=1, and
//    no further strobe until a new push.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the UART transmit FIFO: default widths and the drain
// state encodings used by uart_tx_fifo.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    localparam int UTF_WIDTH_DEF      = 8;
    localparam int UTF_DEPTH_LOG2_DEF = 4;

    // Drain sequencer states. The encodings are fixed so that waveforms and
    // debug probes read the same across builds.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_STROBE = 2'b01,
        S_GAP    = 2'b10
    } drain_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the producer push port, FIFO status and the buart-facing drain port.
//   slave  : the FIFO side (uart_tx_fifo)
//   master : the environment side (producer + buart)
// Signals:
//   push, push_data       producer write request and byte
//   full, empty, level    registered occupancy status
//   uart_busy             buart busy flag
//   uart_wr, uart_data    one-cycle write strobe and held byte to buart
//   overflow, ovf_clr     sticky dropped-push flag and its clear
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH      = UTF_WIDTH_DEF,
    parameter int DEPTH_LOG2 = UTF_DEPTH_LOG2_DEF
);
    logic                  push;
    logic [WIDTH-1:0]      push_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  uart_busy;
    logic                  uart_wr;
    logic [WIDTH-1:0]      uart_data;
    logic                  overflow;
    logic                  ovf_clr;

    modport slave (
        input  push, push_data, uart_busy, ovf_clr,
        output full, empty, level, uart_wr, uart_data, overflow
    );

    modport master (
        output push, push_data, uart_busy, ovf_clr,
        input  full, empty, level, uart_wr, uart_data, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem_2r1w
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Storage is deliberately not reset; the pointers guarantee that only written
// entries are ever read.
// Ports:
//   clk     in  clock
//   we      in  write enable
//   waddr   in  write address
//   wdata   in  write data
//   raddr   in  read address
//   rdata   out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_mem_2r1w #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO between the ROM-driven byte sequencer and the buart transmitter.
// Absorbs single-cycle pushes from the producer and drains them to buart with
// a one-cycle wr strobe, paced by buart's busy flag.
//
// Ports:
//   clk      in   single clock, all state on posedge
//   resetq   in   asynchronous active-low reset
//   bus      slave modport of uart_tx_fifo_if:
//              push/push_data in, full/empty/level out,
//              uart_busy in, uart_wr/uart_data out,
//              overflow out, ovf_clr in
//
// Build option:
//   UART_TX_FIFO_OVF_EN  defined   -> sticky overflow flag, cleared by ovf_clr
//                        undefined -> overflow tied low, ovf_clr ignored
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UTF_DEPTH_LOG2_DEF,
    parameter int WIDTH      = UTF_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           resetq,
    uart_tx_fifo_if.slave  bus
);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;

    drain_state_e        state_q, state_d;
    logic                uart_wr_q, uart_wr_d;
    logic [WIDTH-1:0]    uart_data_q, uart_data_d;

    logic [WIDTH-1:0]    rd_data;
    logic                push_ok;
    logic                pop;

    // Both decisions use the registered flags: a push at full is dropped even
    // if a pop happens on the same edge, and a push into an empty FIFO cannot
    // be popped until the following edge.
    assign push_ok = bus.push && !full_q;
    assign pop     = (state_q == S_IDLE) && !empty_q && !bus.uart_busy;

    fifo_mem_2r1w #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (bus.push_data),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

    // ---------------------------------------------------------------- pointers
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (level_d == FULL_LEVEL);
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.level = wr_ptr_q - rd_ptr_q;

    // --------------------------------------------------------------- drain FSM
    // State register
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. STROBE and GAP always take one cycle each, so strobes are at
    // least three cycles apart and buart has a full cycle to raise busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pop) state_d = S_STROBE;
            S_STROBE: state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs. uart_data holds the last byte sent until the next pop.
    always_comb begin
        uart_wr_d   = 1'b0;
        uart_data_d = uart_data_q;
        case (state_q)
            S_IDLE: begin
                uart_wr_d = pop;
                if (pop) uart_data_d = rd_data;
            end
            default: uart_wr_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            uart_wr_q   <= 1'b0;
            uart_data_q <= '0;
        end else begin
            uart_wr_q   <= uart_wr_d;
            uart_data_q <= uart_data_d;
        end
    end

    assign bus.uart_wr   = uart_wr_q;
    assign bus.uart_data = uart_data_q;

    // ---------------------------------------------------------------- overflow
`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.push && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo. A queue-based model predicts the outputs every
// cycle; directed scenarios add literal expectations on top. A simple buart
// stand-in holds busy for 10 cycles after each strobe.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int W     = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic clk    = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ buart model
    logic       force_busy = 1'b0;
    int         busy_cnt   = 0;
    logic [7:0] rx[$];

    assign bus.uart_busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (bus.uart_wr === 1'b1) begin
            rx.push_back(bus.uart_data);
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    // ------------------------------------------------------- reference model
    // The FIFO is a queue; a byte leaves when the queue is non-empty, buart is
    // idle, and at least three cycles have passed since the previous strobe.
    logic [7:0] m_q[$];
    int         m_cool = 0;
    logic       m_wr   = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf  = 1'b0;

    always @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            m_q.delete();
            m_cool = 0;
            m_wr   = 1'b0;
            m_data = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (m_q.size() != 0) && !bus.uart_busy && (m_cool == 0);
            do_push = bus.push && (m_q.size() != DEPTH);
`ifdef UART_TX_FIFO_OVF_EN
            if (bus.push && m_q.size() == DEPTH) m_ovf = 1'b1;
            else if (bus.ovf_clr)                 m_ovf = 1'b0;
`endif
            if (do_pop) m_data = m_q.pop_front();
            m_wr   = do_pop;
            m_cool = do_pop ? 2 : (m_cool > 0 ? m_cool - 1 : 0);
            if (do_push) m_q.push_back(bus.push_data);
        end
    end

    always @(negedge clk) begin
        chk("m_uart_wr",   32'(bus.uart_wr),   32'(m_wr));
        chk("m_uart_data", 32'(bus.uart_data), 32'(m_data));
        chk("m_level",     32'(bus.level),     32'(m_q.size()));
        chk("m_empty",     32'(bus.empty),     32'(m_q.size() == 0));
        chk("m_full",      32'(bus.full),      32'(m_q.size() == DEPTH));
        chk("m_overflow",  32'(bus.overflow),  32'(m_ovf));
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("rx_timeout", 32'(rx.size() >= n), 32'd1);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int base;
        logic exp_ovf;
`ifdef UART_TX_FIFO_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.ovf_clr   = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_empty",    32'(bus.empty),     32'd1);
        chk("rst_full",     32'(bus.full),      32'd0);
        chk("rst_level",    32'(bus.level),     32'd0);
        chk("rst_uart_wr",  32'(bus.uart_wr),   32'd0);
        chk("rst_data",     32'(bus.uart_data), 32'd0);
        chk("rst_overflow", 32'(bus.overflow),  32'd0);
        resetq = 1'b1;
        tick();

        // 1: single byte, 2-cycle push-to-strobe
        bus.push = 1'b1; bus.push_data = 8'h41;
        tick();
        bus.push = 1'b0;
        chk("t1_empty_after_push", 32'(bus.empty),   32'd0);
        chk("t1_no_wr_yet",        32'(bus.uart_wr), 32'd0);
        tick();
        chk("t1_wr",          32'(bus.uart_wr),   32'd1);
        chk("t1_data",        32'(bus.uart_data), 32'h41);
        chk("t1_empty_after", 32'(bus.empty),     32'd1);
        repeat (20) tick();

        // 2: fill while busy
        base = rx.size();
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1; bus.push_data = 8'(i);
            tick();
        end
        bus.push = 1'b0;
        chk("t2_full",  32'(bus.full),  32'd1);
        chk("t2_level", 32'(bus.level), 32'd16);
        chk("t2_no_tx", 32'(rx.size()), 32'(base));

        // 3: push into a full FIFO is dropped
        bus.push = 1'b1; bus.push_data = 8'hEE;
        tick();
        bus.push = 1'b0;
        chk("t3_level",    32'(bus.level),    32'd16);
        chk("t3_overflow", 32'(bus.overflow), 32'(exp_ovf));
        tick();
        chk("t3_ovf_hold", 32'(bus.overflow), 32'(exp_ovf));
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr",  32'(bus.overflow), 32'd0);

        // 2 (cont.): drain with the busy model
        force_busy = 1'b0;
        wait_rx(base + 16, 400);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t2_rx%0d", i), 32'(rx[base + i]), 32'(i));
        repeat (20) tick();

        // 4: push and pop on the same edge at level 1
        base = rx.size();
        force_busy = 1'b1;
        bus.push = 1'b1; bus.push_data = 8'h33;
        tick();
        chk("t4_level1", 32'(bus.level), 32'd1);
        force_busy = 1'b0;
        bus.push_data = 8'h55;
        tick();
        bus.push = 1'b0;
        chk("t4_level_kept", 32'(bus.level),     32'd1);
        chk("t4_wr",         32'(bus.uart_wr),   32'd1);
        chk("t4_data",       32'(bus.uart_data), 32'h33);
        wait_rx(base + 2, 100);
        chk("t4_next", 32'(rx[base + 1]), 32'h55);
        repeat (20) tick();

        // 5: 40 bytes in 4 bursts of 10, across pointer wrap
        base = rx.size();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                bus.push = 1'b1; bus.push_data = 8'(8'h80 + b * 10 + i);
                tick();
            end
            bus.push = 1'b0;
            repeat (140) tick();
        end
        wait_rx(base + 40, 300);
        chk("t5_count", 32'(rx.size()), 32'(base + 40));
        for (int i = 0; i < 40; i++)
            chk($sformatf("t5_rx%0d", i), 32'(rx[base + i]), 32'(8'h80 + i));
        repeat (20) tick();

        // 6: reset during S_STROBE
        base = rx.size();
        bus.push = 1'b1; bus.push_data = 8'hA0;
        tick();
        bus.push_data = 8'hA1;
        tick();
        bus.push = 1'b0;
        chk("t6_strobe", 32'(bus.uart_wr), 32'd1);
        chk("t6_level",  32'(bus.level),   32'd1);
        #2;
        resetq = 1'b0;
        #1;
        chk("t6_rst_wr",    32'(bus.uart_wr), 32'd0);
        chk("t6_rst_empty", 32'(bus.empty),   32'd1);
        chk("t6_rst_level", 32'(bus.level),   32'd0);
        tick();
        resetq = 1'b1;
        repeat (20) tick();
        chk("t6_no_more_tx", 32'(rx.size()),  32'(base + 1));
        chk("t6_idle_wr",    32'(bus.uart_wr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
